// File: rtl/conv_encoder_param.sv
// Rate-1/N convolutional encoder, constraint length K, with valid/ready streaming
// and optional zero-tail flush that returns the encoder to the all-zero state per frame.
module conv_encoder_param #(
    parameter int             K       = 3,
    parameter int             N       = 2,
    parameter logic [N*K-1:0] G       = 6'b101_111,
    parameter bit             TAIL_EN = 1'b1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bit,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sym,
    output logic         out_last
);
    localparam int TW = $clog2(K) + 1;

    typedef enum logic {DATA, FLUSH} state_t;

    state_t          state_reg, state_next;
    logic [K-2:0]    sr_reg, sr_next;
    logic [TW-1:0]   tail_cnt_reg, tail_cnt_next;
    logic            out_valid_reg, out_valid_next;
    logic            out_last_reg, out_last_next;
    logic [N-1:0]    out_sym_reg, out_sym_next;

    logic            cur_bit;
    logic [K-1:0]    window;
    logic [N-1:0]    sym;
    logic            slot_free;

    // Tail bits are zeros; window[j] is the bit accepted j steps ago.
    assign cur_bit = (state_reg == DATA) ? in_bit : 1'b0;
    assign window  = {sr_reg, cur_bit};

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_sym
            assign sym[gi] = ^(G[gi*K +: K] & window);
        end
    endgenerate

    assign slot_free = !out_valid_reg || out_ready;
    assign in_ready  = (state_reg == DATA) && slot_free;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= DATA;
            sr_reg        <= '0;
            tail_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_sym_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            sr_reg        <= sr_next;
            tail_cnt_reg  <= tail_cnt_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            out_sym_reg   <= out_sym_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sr_next        = sr_reg;
        tail_cnt_next  = tail_cnt_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        out_sym_next   = out_sym_reg;

        if (slot_free) begin
            // Slot drained with nothing new: drop valid; overwritten below on a load.
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
            if (state_reg == DATA) begin
                if (in_valid) begin
                    out_sym_next   = sym;
                    out_valid_next = 1'b1;
                    sr_next        = window[K-2:0];
                    if (in_last) begin
                        if (TAIL_EN) begin
                            state_next    = FLUSH;
                            tail_cnt_next = TW'(K - 1);
                        end else begin
                            out_last_next = 1'b1;
                            sr_next       = '0;
                        end
                    end
                end
            end else begin
                out_sym_next   = sym;
                out_valid_next = 1'b1;
                sr_next        = window[K-2:0];
                tail_cnt_next  = tail_cnt_reg - TW'(1);
                if (tail_cnt_reg == TW'(1)) begin
                    out_last_next = 1'b1;
                    state_next    = DATA;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_sym   = out_sym_reg;
endmodule

// File: tb/tb_conv_encoder_param.sv
// Bench for conv_encoder_param: three instances (default, truncated frames, K=4/N=3)
// checked against a frame-level convolution model plus hand-computed symbol literals.
module tb_conv_encoder_param;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    logic in_valid[3], in_ready[3], in_bit[3], in_last[3];
    logic out_valid[3], out_ready[3], out_last[3];
    logic [1:0] sym0, sym1;
    logic [2:0] sym2;
    bit   tog[3];

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[3][$];
    logic [8:0] obs_q[3][$];
    logic [8:0] hold_val[3];
    bit         hold_v[3];

    conv_encoder_param u0 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_bit(in_bit[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_sym(sym0), .out_last(out_last[0]));

    conv_encoder_param #(.K(3), .N(2), .G(6'b101_111), .TAIL_EN(1'b0)) u1 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_bit(in_bit[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_sym(sym1), .out_last(out_last[1]));

    conv_encoder_param #(.K(4), .N(3), .G({4'b1011, 4'b1101, 4'b1111}), .TAIL_EN(1'b1)) u2 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_bit(in_bit[2]), .in_last(in_last[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_sym(sym2), .out_last(out_last[2]));

    function automatic logic [8:0] cur_word(int d);
        logic [7:0] s;
        case (d)
            0:       s = {6'd0, sym0};
            1:       s = {6'd0, sym1};
            default: s = {5'd0, sym2};
        endcase
        return {out_last[d], s};
    endfunction

    // Reference: each output is the GF(2) convolution of the frame (zero before it,
    // zero tail after it when enabled) with that output's generator.
    task automatic model(int d, logic [63:0] bits, int len);
        int k, n, tot;
        logic [11:0] g;
        bit tail;
        logic [7:0] s;
        if (d == 2) begin
            k = 4; n = 3; g = {4'b1011, 4'b1101, 4'b1111}; tail = 1'b1;
        end else begin
            k = 3; n = 2; g = {6'd0, 6'b101_111}; tail = (d == 0);
        end
        tot = len + (tail ? k - 1 : 0);
        for (int t = 0; t < tot; t++) begin
            s = '0;
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < k; j++) begin
                    int idx;
                    idx = t - j;
                    if (idx >= 0 && idx < len)
                        s[i] = s[i] ^ (g[i*k+j] & bits[idx]);
                end
            end
            exp_q[d].push_back({(t == tot - 1), s});
        end
    endtask

    task automatic clear_all();
        for (int d = 0; d < 3; d++) begin
            exp_q[d].delete();
            obs_q[d].delete();
            hold_v[d] = 1'b0;
        end
    endtask

    // Ready pattern: constant 1, or toggling every cycle.
    initial begin
        for (int d = 0; d < 3; d++) out_ready[d] = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            for (int d = 0; d < 3; d++) out_ready[d] = tog[d] ? !out_ready[d] : 1'b1;
        end
    end

    // Compare process: every transfer against the model, every stall for stability.
    initial begin
        logic [8:0] cur, e;
        forever begin
            @(negedge CLK);
            if (RST_N) begin
                for (int d = 0; d < 3; d++) begin
                    cur = cur_word(d);
                    if (hold_v[d]) begin
                        total++;
                        if (cur !== hold_val[d]) begin
                            bad++;
                            $display("FAIL stall_hold dut%0d got=%h want=%h", d, cur, hold_val[d]);
                        end
                    end
                    hold_v[d]   = out_valid[d] && !out_ready[d];
                    hold_val[d] = cur;
                    if (out_valid[d] && out_ready[d]) begin
                        total++;
                        obs_q[d].push_back(cur);
                        if (exp_q[d].size() == 0) begin
                            bad++;
                            $display("FAIL extra_sym dut%0d got=%h want=none", d, cur);
                        end else begin
                            e = exp_q[d].pop_front();
                            if (cur !== e) begin
                                bad++;
                                $display("FAIL sym dut%0d got=%h want=%h", d, cur, e);
                            end
                            $display("dut%0d sym=%h last=%0b", d, cur[7:0], cur[8]);
                        end
                    end
                end
            end
        end
    end

    task automatic send_frame(int d, logic [63:0] bits, int len);
        model(d, bits, len);
        for (int i = 0; i < len; i++) begin
            bit acc;
            int guard;
            in_valid[d] = 1'b1;
            in_bit[d]   = bits[i];
            in_last[d]  = (i == len - 1);
            acc   = 1'b0;
            guard = 0;
            while (!acc) begin
                @(negedge CLK);
                acc = in_ready[d];
                @(posedge CLK);
                #1;
                guard++;
                if (!acc && guard > 50) begin
                    total++; bad++;
                    $display("FAIL accept_timeout dut%0d got=stuck want=accept", d);
                    acc = 1'b1;
                end
            end
        end
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
    endtask

    task automatic drain(int d);
        int guard;
        guard = 0;
        while (exp_q[d].size() != 0 && guard < 300) begin
            @(posedge CLK);
            guard++;
        end
        @(posedge CLK);
        #1;
        total++;
        if (exp_q[d].size() != 0) begin
            bad++;
            $display("FAIL drain dut%0d got=%0d_left want=0", d, exp_q[d].size());
        end
    endtask

    task automatic check_obs(int d, int idx, logic [8:0] want, string name);
        total++;
        if (idx >= obs_q[d].size()) begin
            bad++;
            $display("FAIL %s got=missing want=%h", name, want);
        end else if (obs_q[d][idx] !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, obs_q[d][idx], want);
        end
    endtask

    task automatic check_bit(logic got, logic want, string name);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0b want=%0b", name, got, want);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; in_bit[d] = 1'b0; in_last[d] = 1'b0; tog[d] = 1'b0;
        end
        clear_all();
        repeat (3) @(posedge CLK);
        #1;
        for (int d = 0; d < 3; d++) begin
            check_bit(out_valid[d], 1'b0, "reset_out_valid");
            check_bit(out_last[d], 1'b0, "reset_out_last");
            check_bit(in_ready[d], 1'b1, "reset_in_ready");
        end
        check_bit(|sym0, 1'b0, "reset_out_sym0");
        check_bit(|sym2, 1'b0, "reset_out_sym2");
        RST_N = 1'b1;

        // Frame 1,0,1,1 -> 11,01,00,10, tail 10,11; in_ready low during the tail.
        send_frame(0, 64'b1101, 4);
        @(negedge CLK); check_bit(in_ready[0], 1'b0, "tail_in_ready_1");
        @(negedge CLK); check_bit(in_ready[0], 1'b0, "tail_in_ready_2");
        @(negedge CLK); check_bit(in_ready[0], 1'b1, "tail_in_ready_done");
        drain(0);
        check_obs(0, 0, 9'h003, "lit_t1_s0");
        check_obs(0, 1, 9'h001, "lit_t1_s1");
        check_obs(0, 2, 9'h000, "lit_t1_s2");
        check_obs(0, 3, 9'h002, "lit_t1_s3");
        check_obs(0, 4, 9'h002, "lit_t1_s4");
        check_obs(0, 5, 9'h103, "lit_t1_s5_last");
        obs_q[0].delete();

        // Same frame with out_ready toggling.
        tog[0] = 1'b1;
        send_frame(0, 64'b1101, 4);
        drain(0);
        tog[0] = 1'b0;
        check_obs(0, 1, 9'h001, "lit_tog_s1");
        check_obs(0, 5, 9'h103, "lit_tog_s5_last");
        obs_q[0].delete();

        // Back-to-back {1,1} then {1}: second frame starts from zero state.
        send_frame(0, 64'b11, 2);
        send_frame(0, 64'b1, 1);
        drain(0);
        check_obs(0, 3, 9'h103, "lit_b2b_f1_last");
        check_obs(0, 4, 9'h003, "lit_b2b_f2_first");
        check_obs(0, 6, 9'h103, "lit_b2b_f2_last");
        obs_q[0].delete();

        // Truncated frames: 1,0,1,1 -> 11,01,00,10(last); then {0} -> 00(last).
        send_frame(1, 64'b1101, 4);
        send_frame(1, 64'b0, 1);
        drain(1);
        check_obs(1, 3, 9'h102, "lit_trunc_s3_last");
        check_obs(1, 0, 9'h003, "lit_trunc_s0");
        check_obs(1, 4, 9'h100, "lit_trunc_next_zero");

        // Reset during flush, then a fresh frame {1,1}.
        send_frame(0, 64'b1101, 4);
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        clear_all();
        #1;
        check_bit(out_valid[0], 1'b0, "rst_flush_out_valid");
        check_bit(in_ready[0], 1'b1, "rst_flush_in_ready");
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        send_frame(0, 64'b11, 2);
        drain(0);
        check_obs(0, 0, 9'h003, "lit_after_rst_first");
        check_obs(0, 3, 9'h103, "lit_after_rst_last");

        // K=4, N=3: random 64-bit frames, steady and stalled.
        send_frame(2, {$urandom, $urandom}, 64);
        drain(2);
        tog[2] = 1'b1;
        send_frame(2, {$urandom, $urandom}, 64);
        drain(2);
        tog[2] = 1'b0;
        check_bit(obs_q[2][obs_q[2].size()-1][8], 1'b1, "k4_final_last");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end
endmodule

// File: doc/conv_encoder_param.md
Name: conv_encoder_param

Overview:
Parametrised rate-1/N convolutional encoder with constraint length K and per-output generator polynomials. Streams framed input bits through a valid/ready handshake and emits one N-bit code symbol per input bit from a registered output stage. Optional zero-tail termination flushes the encoder to the all-zero state at the end of each frame. Successor to the fixed 3-cell, rate-1/2 encoder; it sits between the framing logic and the modulator/interleaver.

Parameters:
K, 3, constraint length (>=2); encoder holds K-1 history bits.
N, 2, code symbol width (outputs per input bit), >=1.
G, 6'b101_111, packed generators, N*K bits; G[i*K+j] taps window bit j for output i.
TAIL_EN, 1, 1 = append K-1 zero tail bits after each frame; 0 = truncated frames.

Ports:
CLK  input  1  clock, rising edge.
RST_N  input  1  asynchronous active-low reset.
in_valid  input  1  in_bit/in_last valid.
in_ready  output  1  encoder accepts input this cycle.
in_bit  input  1  data bit.
in_last  input  1  marks last data bit of frame.
out_valid  output  1  out_sym valid.
out_ready  input  1  downstream accepts symbol.
out_sym  output  N  code symbol; bit i = output i.
out_last  output  1  marks final symbol of frame (incl. tail).

Behaviour:
- Reset (RST_N low, async): sr=0 (K-1 bits), out_valid=0, out_sym=0, out_last=0, state=DATA, tail_cnt=0. Takes effect immediately, including mid-frame or mid-flush; the partial frame is discarded.
- Window w[K-1:0]: w[0]=current bit (in_bit or tail 0), w[j]=sr[j-1], i.e. the bit accepted j steps earlier.
- Symbol: out_sym[i] = XOR over j of (G[i*K+j] & w[j]). Pure GF(2), no integer arithmetic.
- slot_free = !out_valid || out_ready. Output register loads only when slot_free.
- in_ready = (state==DATA) && slot_free. Accept = in_valid && in_ready.
- On accept: out_sym<=symbol, out_valid<=1, sr<={sr[K-3:0],in_bit} (K=2: sr<=in_bit). Latency: symbol visible the cycle after accept.
- in_last accepted, TAIL_EN=0: out_last<=1 on that symbol; sr<=0 (next frame starts from zero state).
- in_last accepted, TAIL_EN=1: out_last<=0; state<=FLUSH; tail_cnt<=K-1.
- FLUSH: in_ready=0. Each cycle with slot_free: load symbol computed with w[0]=0, shift 0 into sr, tail_cnt--. When the tail_cnt==1 symbol is loaded, set out_last=1 and state<=DATA. After flush, sr is all-zero by construction.
- out_valid && !out_ready: out_sym, out_last held stable, no state change, in_ready=0.
- Output consumed with no new load: out_valid<=0, out_last<=0.
- Full throughput: one symbol/cycle with continuous in_valid and out_ready. Each frame costs K-1 extra cycles when TAIL_EN=1.
- in_valid while in FLUSH: ignored (not accepted); the source must hold it.
- Frame of one bit is legal and is handled identically.

Test Plan:
- Defaults, out_ready=1; bits 1,0,1,1 (last on 4th) -> out_sym 11,01,00,10, then tail 10,11; out_last only on the 6th symbol; in_ready=0 during the 2 tail cycles.
- Same frame, out_ready toggled 1/0 every cycle -> identical symbol sequence; out_sym stable while stalled; no bit lost or duplicated.
- Two back-to-back frames {1,1} and {1} -> frame 2 symbols start from zero state: first symbol 11, identical to a fresh-after-reset encode.
- TAIL_EN=0, bits 1,0,1,1 -> symbols 11,01,00,10 with out_last on 4th; the next frame's first bit 0 gives 00.
- Assert RST_N low during the FLUSH of frame 1 -> out_valid=0 and in_ready returns to 1 asynchronously/next cycle; the following frame encodes as from reset.
- K=4, N=3, G={4'b1011,4'b1101,4'b1111}, random 64-bit frames -> matches a reference model bit-exactly, including 3 tail symbols.
